sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO with runtime-programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It succeeds the fixed-configuration 512x44 FIFO wrapper for same-clock-domain buffering in the 10G raw link datapath, for example between the MAC framing logic and the lane packer. The block has generic width and depth and needs no vendor FIFO primitive: storage is an inferred simple dual-port RAM.

---
 rtl/sync_fifo_prog.sv | 88 ++++++++
 tb/tb_sync_fifo_prog.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost flags, sync flush and sticky error flags
// Ports: clk; rst_n (async, active low); clr (sync flush); wr_en/wr_data -> wr_full, almost_full (af_thresh);
//        rd_en -> rd_data, rd_empty, almost_empty (ae_thresh); water_level; overflow/underflow (sticky).
// Build option: define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through reads (standard reads otherwise).
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 44,
  parameter int DEPTH_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
);
  localparam logic [DEPTH_WIDTH:0] cap = (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);
  logic [DATA_WIDTH-1:0] mem [1 << DEPTH_WIDTH];
  logic [DEPTH_WIDTH:0] wr_ptr, rd_ptr, level_next;
  logic wr_acc, rd_acc, rd_step;
  assign wr_acc = wr_en & ~wr_full & ~clr;
  assign rd_acc = rd_en & ~rd_empty & ~clr;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      water_level <= '0;
      wr_full <= 1'b0;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= clr ? '0 : wr_ptr + (DEPTH_WIDTH+1)'(wr_acc);
      rd_ptr <= clr ? '0 : rd_ptr + (DEPTH_WIDTH+1)'(rd_step);
      water_level <= clr ? '0 : level_next;
      wr_full <= ~clr & (level_next == cap);
      almost_full <= ~clr & (level_next >= af_thresh);
      almost_empty <= clr | (level_next <= ae_thresh);
      overflow <= ~clr & (overflow | (wr_en & wr_full));
      underflow <= ~clr & (underflow | (rd_en & rd_empty));
    end
`ifdef SYNC_FIFO_PROG_FWFT_EN
  // Two-stage read path: synchronous RAM read into mid, then the output register.
  // Both stages count toward the level; rd_ptr is the RAM fetch pointer.
  logic mid_valid, out_valid, out_take, fetch;
  logic [DATA_WIDTH-1:0] mid_data;
  assign rd_empty = ~out_valid;
  assign out_take = ~out_valid | rd_acc;
  assign fetch = ~clr & (wr_ptr != rd_ptr) & (~mid_valid | out_take);
  assign rd_step = fetch;
  assign level_next = water_level + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(rd_acc);
  always_ff @(posedge clk)
    if (fetch) mid_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      mid_valid <= ~clr & (fetch | (mid_valid & ~out_take));
      out_valid <= ~clr & (out_take ? mid_valid : out_valid);
      rd_data <= clr ? '0 : (out_take & mid_valid) ? mid_data : rd_data;
    end
`else
  assign rd_step = rd_acc;
  assign level_next = wr_ptr + (DEPTH_WIDTH+1)'(wr_acc) - rd_ptr - (DEPTH_WIDTH+1)'(rd_acc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data <= '0;
      rd_empty <= 1'b1;
    end else begin
      rd_data <= clr ? '0 : rd_acc ? mem[rd_ptr[DEPTH_WIDTH-1:0]] : rd_data;
      rd_empty <= clr | (level_next == '0);
    end
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
  localparam int DW = 44, AW = 9, DEPTH = 512;
  logic clk = 0, rst_n = 0, clr = 0, wr_en = 0, rd_en = 0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic [AW:0] af_thresh = 10'd400, ae_thresh = 10'd200, water_level;
  logic wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  int total = 0, bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd = '0;
  bit ovf = 0, udf = 0;
  logic [59:0] got, want;
  always #5 clk = ~clk;
  sync_fifo_prog dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .almost_full(almost_full), .af_thresh(af_thresh),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
    .ae_thresh(ae_thresh), .water_level(water_level), .overflow(overflow), .underflow(underflow)
  );
  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction
  task automatic cyc();
    bit wa, ra;
    wa = wr_en && q.size() < DEPTH && !clr;
    ra = rd_en && q.size() > 0 && !clr;
    @(posedge clk);
    if (clr) begin
      q.delete();
      ovf = 0;
      udf = 0;
      exp_rd = '0;
    end else begin
      if (wr_en && q.size() == DEPTH) ovf = 1;
      if (rd_en && q.size() == 0) udf = 1;
      if (ra) exp_rd = q.pop_front();
      if (wa) q.push_back(wr_data);
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    af_thresh = 10'd400;
    ae_thresh = 10'd200;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rd_empty, almost_empty, wr_full, almost_full, overflow, underflow} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=110000", {rd_empty, almost_empty, wr_full, almost_full, overflow, underflow});
    end
    total++;
    if (water_level !== 0 || rd_data !== 0) begin
      bad++;
      $display("FAIL reset_data level=%0d data=%h want 0/0", water_level, rd_data);
    end
    @(negedge clk);
    rst_n = 1;
    cyc();
    total++;
    if ({rd_empty, almost_empty, wr_full, almost_full, water_level, rd_data} !== {4'b1100, 10'd0, 44'd0}) begin
      bad++;
      $display("FAIL post_reset got=%b/%0d/%h", {rd_empty, almost_empty, wr_full, almost_full}, water_level, rd_data);
    end
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1;
      wr_data = DW'(i);
      cyc();
      total++;
      if ({water_level, wr_full, almost_full} !== {10'(i + 1), i + 1 == DEPTH, i + 1 >= 400}) begin
        bad++;
        $display("FAIL fill_%0d got=%0d/%b%b want=%0d", i, water_level, wr_full, almost_full, i + 1);
      end
    end
    wr_en = 0;
    rd_en = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      total++;
      if ({rd_data, rd_empty, almost_empty, water_level} !== {DW'(i), i == DEPTH - 1, DEPTH - 1 - i <= 200, 10'(DEPTH - 1 - i)}) begin
        bad++;
        $display("FAIL drain_%0d data=%0d empty=%b ae=%b level=%0d want data=%0d", i, rd_data, rd_empty, almost_empty, water_level, i);
      end
    end
    rd_en = 0;
  endtask
  task automatic test_ovf_udf();
    wr_en = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = rnd();
      cyc();
    end
    total++;
    if (wr_full !== 1 || overflow !== 0) begin
      bad++;
      $display("FAIL ovf_full full=%b ovf=%b want 1/0", wr_full, overflow);
    end
    rd_en = 1;
    wr_data = rnd();
    cyc();
    wr_en = 0;
    rd_en = 0;
    total++;
    if ({water_level, overflow, rd_data} !== {10'd511, 1'b1, exp_rd}) begin
      bad++;
      $display("FAIL ovf_hit level=%0d ovf=%b data=%h want 511/1/%h", water_level, overflow, rd_data, exp_rd);
    end
    repeat (3) cyc();
    total++;
    if (overflow !== 1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", overflow);
    end
    rd_en = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      cyc();
      total++;
      if (rd_data !== exp_rd) begin
        bad++;
        $display("FAIL ovf_drain_%0d got=%h want=%h", i, rd_data, exp_rd);
      end
    end
    total++;
    if ({rd_empty, underflow, water_level} !== {2'b10, 10'd0}) begin
      bad++;
      $display("FAIL udf_before empty=%b udf=%b level=%0d want 1/0/0", rd_empty, underflow, water_level);
    end
    cyc();
    rd_en = 0;
    total++;
    if ({underflow, overflow, rd_data, water_level} !== {2'b11, exp_rd, 10'd0}) begin
      bad++;
      $display("FAIL udf_hit udf=%b ovf=%b data=%h want 1/1/%h", underflow, overflow, rd_data, exp_rd);
    end
    clr = 1;
    cyc();
    clr = 0;
    total++;
    if ({overflow, underflow, rd_data} !== {2'b00, 44'd0}) begin
      bad++;
      $display("FAIL clr_sticky ovf=%b udf=%b data=%h want 0/0/0", overflow, underflow, rd_data);
    end
  endtask
  task automatic test_back_to_back();
    wr_en = 1;
    repeat (3) begin
      wr_data = rnd();
      cyc();
    end
    rd_en = 1;
    for (int i = 0; i < 2000; i++) begin
      wr_data = rnd();
      cyc();
      total++;
      if ({water_level, rd_data} !== {10'd3, exp_rd}) begin
        bad++;
        $display("FAIL b2b_%0d level=%0d data=%h want 3/%h", i, water_level, rd_data, exp_rd);
      end
    end
    wr_en = 0;
    rd_en = 0;
    clr = 1;
    cyc();
    clr = 0;
  endtask
  task automatic test_clr();
    rd_en = 1;
    cyc();
    rd_en = 0;
    wr_en = 1;
    for (int i = 0; i < 100; i++) begin
      wr_data = rnd();
      cyc();
    end
    total++;
    if ({water_level, underflow, rd_empty} !== {10'd100, 2'b10}) begin
      bad++;
      $display("FAIL clr_pre level=%0d udf=%b empty=%b want 100/1/0", water_level, underflow, rd_empty);
    end
    af_thresh = 10'd50;
    clr = 1;
    wr_data = rnd();
    cyc();
    clr = 0;
    wr_en = 0;
    total++;
    if ({water_level, wr_full, almost_full, rd_empty, almost_empty, overflow, underflow, rd_data} !== {10'd0, 6'b001100, 44'd0}) begin
      bad++;
      $display("FAIL clr_hit level=%0d flags=%b data=%h want 0/001100/0", water_level,
               {wr_full, almost_full, rd_empty, almost_empty, overflow, underflow}, rd_data);
    end
    cyc();
    total++;
    if (water_level !== 0 || rd_empty !== 1) begin
      bad++;
      $display("FAIL clr_drop level=%0d empty=%b want 0/1", water_level, rd_empty);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        af_thresh = 10'($urandom_range(0, 1023));
        ae_thresh = 10'($urandom_range(0, 1023));
      end
      wr_en = $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 85 : 30);
      rd_en = $urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 85);
      wr_data = rnd();
      cyc();
      want = {10'(q.size()), q.size() == DEPTH, q.size() >= int'(af_thresh), q.size() == 0,
              q.size() <= int'(ae_thresh), ovf, udf, exp_rd};
      got = {water_level, wr_full, almost_full, rd_empty, almost_empty, overflow, underflow, rd_data};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rand_%0d got=%h want=%h", i, got, want);
      end
    end
    wr_en = 0;
    rd_en = 0;
  endtask
`ifdef SYNC_FIFO_PROG_FWFT_EN
  task automatic test_fwft();
    wr_en = 1;
    wr_data = 44'hA;
    cyc();
    wr_en = 0;
    total++;
    if (rd_empty !== 1 || water_level !== 1) begin
      bad++;
      $display("FAIL fwft_inflight empty=%b level=%0d want 1/1", rd_empty, water_level);
    end
    cyc();
    total++;
    if (rd_empty !== 1) begin
      bad++;
      $display("FAIL fwft_stage empty=%b want=1", rd_empty);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (rd_empty !== 0 || rd_data !== 44'hA || water_level !== 1) begin
        bad++;
        $display("FAIL fwft_head_%0d empty=%b data=%h level=%0d want 0/a/1", i, rd_empty, rd_data, water_level);
      end
    end
    rd_en = 1;
    cyc();
    rd_en = 0;
    total++;
    if (rd_empty !== 1 || water_level !== 0 || underflow !== 0) begin
      bad++;
      $display("FAIL fwft_consume empty=%b level=%0d udf=%b want 1/0/0", rd_empty, water_level, underflow);
    end
    wr_en = 1;
    wr_data = 44'h11;
    cyc();
    wr_data = 44'h22;
    cyc();
    wr_en = 0;
    repeat (2) cyc();
    total++;
    if (rd_data !== 44'h11 || water_level !== 2) begin
      bad++;
      $display("FAIL fwft_first data=%h level=%0d want 11/2", rd_data, water_level);
    end
    rd_en = 1;
    cyc();
    rd_en = 0;
    total++;
    if (rd_data !== 44'h22 || rd_empty !== 0 || water_level !== 1) begin
      bad++;
      $display("FAIL fwft_next data=%h empty=%b level=%0d want 22/0/1", rd_data, rd_empty, water_level);
    end
    clr = 1;
    cyc();
    clr = 0;
    total++;
    if (rd_empty !== 1 || rd_data !== 0 || water_level !== 0) begin
      bad++;
      $display("FAIL fwft_clr empty=%b data=%h level=%0d want 1/0/0", rd_empty, rd_data, water_level);
    end
  endtask
`endif
  initial begin
    test_reset();
`ifdef SYNC_FIFO_PROG_FWFT_EN
    test_fwft();
`else
    test_fill_drain();
    test_ovf_udf();
    test_back_to_back();
    test_clr();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
